// File: rtl/memory_stage.sv
// MEM stage of the 16-bit core: drives the data-memory req/done handshake,
// stalls upstream while an access is outstanding, and loads the MEM/WB register.
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluOut,
  input  logic [15:0] reg2Data,
  input  logic        memEn,
  input  logic        memWrt,
  input  logic        regWrt,
  input  logic        halt,
  input  logic        errIn,
  input  logic [2:0]  regWrtSrc,
  input  logic [2:0]  writeReg,
  input  logic [15:0] setVal,
  input  logic [15:0] nextPc,
  output logic        dmemReq,
  output logic        dmemWr,
  output logic [15:0] dmemAddr,
  output logic [15:0] dmemWrData,
  input  logic [15:0] dmemRdData,
  input  logic        dmemDone,
  output logic        stall,
  output logic [15:0] memDataOut,
  output logic [15:0] aluOutOut,
  output logic [15:0] setValOut,
  output logic [15:0] nextPcOut,
  output logic        regWrtOut,
  output logic        haltOut,
  output logic        errOut,
  output logic [2:0]  regWrtSrcOut,
  output logic [2:0]  writeRegOut
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;

  logic        is_idle, is_wait;
  logic        misal, tmo, complete, passthru, load;
  logic [15:0] rd_d;

  assign is_idle    = (state_q == S_IDLE);
  assign is_wait    = (state_q == S_WAIT);
  assign misal      = memEn & aluOut[0];

  assign dmemReq    = (is_idle & memEn & ~misal) | is_wait;
  assign dmemWr     = memWrt;
  assign dmemAddr   = aluOut;
  assign dmemWrData = reg2Data;

  assign tmo        = is_wait & (cnt_q == 8'(TIMEOUT - 1)) & ~dmemDone;
  assign stall      = dmemReq & ~dmemDone & ~tmo;
  assign complete   = dmemReq & (dmemDone | tmo);
  assign passthru   = is_idle & (~memEn | misal);
  assign load       = passthru | complete;

  // Read data is only meaningful for a read that really finished via done.
  assign rd_d       = (complete & dmemDone & ~memWrt) ? dmemRdData : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      memDataOut   <= '0;
      aluOutOut    <= '0;
      setValOut    <= '0;
      nextPcOut    <= '0;
      regWrtOut    <= 1'b0;
      haltOut      <= 1'b0;
      errOut       <= 1'b0;
      regWrtSrcOut <= '0;
      writeRegOut  <= '0;
    end else if (load) begin
      memDataOut   <= rd_d;
      aluOutOut    <= aluOut;
      setValOut    <= setVal;
      nextPcOut    <= nextPc;
      regWrtOut    <= regWrt & ~misal & ~tmo;
      haltOut      <= halt;
      errOut       <= errIn | misal | tmo;
      regWrtSrcOut <= regWrtSrc;
      writeRegOut  <= writeReg;
      cnt_q        <= '0;
      state_q      <= halt ? S_HALTED : S_IDLE;
    end else begin
      // Bubble: kill control bits, data fields hold. HALTED lands here every cycle.
      regWrtOut <= 1'b0;
      haltOut   <= 1'b0;
      errOut    <= 1'b0;
      if (is_idle) begin
        state_q <= S_WAIT;
        cnt_q   <= 8'd1;
      end else if (is_wait) begin
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

endmodule
